// File: rtl/seq_dtree_ctrl.sv
// seq_dtree_ctrl: sequential decision-tree evaluator sharing one feature mux and one <= comparator across all nodes.
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid/in_ready   : sample handshake, in_x holds N_FEAT packed features
//   out_valid/out_ready : result handshake, out_class/out_err held while out_valid
//   cfg_we/addr/data    : node-table write, honoured only while idle
//   busy                : evaluating or holding a result
module seq_dtree_ctrl #(
  parameter int N_FEAT = 5,
  parameter int FEAT_W = 8,
  parameter int NODES = 16,
  parameter int MAX_DEPTH = 8,
  parameter int CLASS_W = 6,
  localparam int AW = $clog2(NODES),
  localparam int WW = 4 + FEAT_W + 2 * AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [WW-1:0]            cfg_data,
  output logic                     busy
);
  localparam int SW = $clog2(MAX_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state, nxt;
  logic [WW-1:0] tbl [NODES];
  logic [N_FEAT*FEAT_W-1:0] x;
  logic [AW-1:0] ptr;
  logic [SW-1:0] step;
  logic [CLASS_W-1:0] cls;
  logic err;
  logic [WW-1:0] node;
  logic leaf, bad, last;
  logic [2:0] feat;
  logic [FEAT_W-1:0] thr, xf;
  logic [AW-1:0] left, right;
  logic [2*AW-1:0] lr;
  assign node = tbl[ptr];
  assign leaf = node[WW-1];
  assign feat = node[WW-2 -: 3];
  assign thr = node[2*AW +: FEAT_W];
  assign left = node[AW +: AW];
  assign right = node[0 +: AW];
  assign lr = node[2*AW-1:0];
  assign bad = int'(feat) >= N_FEAT;
  assign last = step == SW'(MAX_DEPTH - 1);
  // out-of-range feature indices select zero; they abort anyway via bad
  always_comb begin
    xf = '0;
    for (int i = 0; i < N_FEAT; i++) if (int'(feat) == i) xf = x[i*FEAT_W +: FEAT_W];
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = in_valid ? EVAL : IDLE;
      EVAL: nxt = (leaf || bad || last) ? DONE : EVAL;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      ptr <= '0;
      step <= '0;
      cls <= '0;
      err <= 1'b0;
      for (int i = 0; i < NODES; i++) tbl[i] <= '0;
    end else begin
      state <= nxt;
      // writes land on the accepting edge too, so a same-edge write is seen by the walk
      if (state == IDLE && cfg_we) tbl[cfg_addr] <= cfg_data;
      if (state == IDLE && in_valid) begin
        x <= in_x;
        ptr <= '0;
        step <= '0;
      end
      if (state == EVAL) begin
        if (leaf) begin
          cls <= lr[CLASS_W-1:0];
          err <= 1'b0;
        end else if (bad || last) begin
          cls <= '0;
          err <= 1'b1;
        end else begin
          ptr <= (xf <= thr) ? left : right;
          step <= step + 1'b1;
        end
      end
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_class = cls;
  assign out_err = err;
endmodule

// File: tb/tb_seq_dtree_ctrl.sv
// tb_seq_dtree_ctrl: directed bench with a path-walking reference model for seq_dtree_ctrl.
module tb_seq_dtree_ctrl;
  localparam int NF = 5;
  localparam int MAXD = 8;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, cfg_we;
  logic in_ready, out_valid, out_err, busy;
  logic [39:0] in_x;
  logic [5:0] out_class;
  logic [3:0] cfg_addr;
  logic [19:0] cfg_data;
  int n_tests = 0;
  int n_fail = 0;
  seq_dtree_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string n, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction
  function automatic logic [19:0] nd(input int f, input int thr, input int l, input int r);
    return {1'b0, 3'(f), 8'(thr), 4'(l), 4'(r)};
  endfunction
  function automatic logic [19:0] lf(input int c);
    return {1'b1, 3'b0, 8'b0, 8'(c)};
  endfunction
  function automatic logic [39:0] px(input int f0, input int f1, input int f2, input int f3, input int f4);
    return {8'(f4), 8'(f3), 8'(f2), 8'(f1), 8'(f0)};
  endfunction
  // reference model: table copy, phase (0 idle, 1 walking, 2 result), cycles left, result
  logic [19:0] mt [16];
  int m_ph = 0;
  int m_cnt = 0;
  logic [5:0] m_cls = '0;
  logic m_err = 1'b0;
  function automatic void meval(input logic [39:0] xx, output int lat, output logic [5:0] c, output logic e);
    int p, f;
    bit fin;
    logic [19:0] w;
    p = 0; fin = 0; lat = MAXD; c = '0; e = 1'b1;
    for (int s = 0; s < MAXD && !fin; s++) begin
      w = mt[p];
      f = int'(w[18:16]);
      if (w[19]) begin
        c = w[5:0]; e = 1'b0; lat = s + 1; fin = 1;
      end else if (f >= NF || s == MAXD - 1) begin
        lat = s + 1; fin = 1;
      end else begin
        p = (xx[f*8 +: 8] <= w[15:8]) ? int'(w[7:4]) : int'(w[3:0]);
      end
    end
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0;
      for (int i = 0; i < 16; i++) mt[i] = '0;
    end else begin
      case (m_ph)
        0: begin
          if (cfg_we) mt[cfg_addr] = cfg_data;
          if (in_valid) begin
            meval(in_x, m_cnt, m_cls, m_err);
            m_ph = 1;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_ph = 2;
        end
        default: if (out_ready) m_ph = 0;
      endcase
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_in_ready", int'(in_ready), int'(m_ph == 0));
      chk("m_out_valid", int'(out_valid), int'(m_ph == 2));
      chk("m_busy", int'(busy), int'(m_ph != 0));
      if (m_ph == 2) begin
        chk("m_out_class", int'(out_class), int'(m_cls));
        chk("m_out_err", int'(out_err), int'(m_err));
      end
    end
  end
  task automatic wr(input int a, input logic [19:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  // one sample: optional same-edge write (swa>=0), hold cycles of backpressure, optional ignored write while holding
  task automatic run(input logic [39:0] xx, input int swa, input logic [19:0] swd, input int hold, input bit wrh,
                     input int ec, input int ee, input int el, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, "_ready"}, int'(in_ready), 1);
    in_x = xx; in_valid = 1'b1; out_ready = 1'b0;
    if (swa >= 0) begin
      cfg_we = 1'b1; cfg_addr = 4'(swa); cfg_data = swd;
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; in_x = '1;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk({nm, "_busy_ready"}, int'(in_ready), 0);
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, cyc, el);
    chk({nm, "_class"}, int'(out_class), ec);
    chk({nm, "_err"}, int'(out_err), ee);
    for (int i = 0; i < hold; i++) begin
      if (wrh && i == 0) begin
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = lf(9);
      end else cfg_we = 1'b0;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    chk({nm, "_hold_class"}, int'(out_class), ec);
    chk({nm, "_hold_ready"}, int'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_released"}, int'(out_valid), 0);
  endtask
  task automatic load_d3();
    wr(0, nd(4, 15, 1, 5)); wr(1, nd(1, 5, 2, 6)); wr(2, nd(3, 7, 3, 7)); wr(3, lf(37));
  endtask
  initial begin
    int na, nv;
    int acc [2];
    int hs [2];
    int cl [2];
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    wr(0, nd(0, 100, 1, 2)); wr(1, lf(3)); wr(2, lf(43));
    run(px(100, 0, 0, 0, 0), -1, '0, 0, 0, 3, 0, 2, "a_eq");
    run(px(101, 0, 0, 0, 0), -1, '0, 0, 0, 43, 0, 2, "a_gt");
    run(px(255, 9, 9, 9, 9), -1, '0, 0, 0, 43, 0, 2, "a_max");
    load_d3();
    wr(5, lf(50)); wr(6, lf(51)); wr(7, lf(52));
    run(px(0, 0, 0, 7, 15), -1, '0, 0, 0, 37, 0, 4, "d3");
    run(px(0, 6, 0, 0, 15), -1, '0, 0, 0, 51, 0, 3, "d3_r6");
    run(px(0, 0, 0, 8, 15), -1, '0, 0, 0, 52, 0, 4, "d3_r7");
    run(px(0, 0, 0, 0, 16), -1, '0, 0, 0, 50, 0, 2, "d3_r5");
    wr(0, nd(0, 255, 0, 0));
    run(px(7, 0, 0, 0, 0), -1, '0, 0, 0, 0, 1, 8, "loop");
    wr(0, nd(6, 0, 1, 2));
    run(px(0, 0, 0, 0, 0), -1, '0, 0, 0, 0, 1, 1, "feat6");
    wr(0, nd(5, 0, 1, 2));
    run(px(0, 0, 0, 0, 0), -1, '0, 0, 0, 0, 1, 1, "feat5");
    run(px(0, 0, 0, 0, 0), 0, lf(21), 0, 0, 21, 0, 1, "same_edge");
    wr(0, nd(0, 100, 1, 2)); wr(1, lf(3)); wr(2, lf(43));
    run(px(100, 0, 0, 0, 0), -1, '0, 5, 1, 3, 0, 2, "bp");
    run(px(50, 0, 0, 0, 0), -1, '0, 0, 0, 3, 0, 2, "bp_old_node1");
    na = 0; nv = 0;
    acc = '{0, 0}; hs = '{0, 0}; cl = '{0, 0};
    @(negedge clk);
    in_x = px(100, 0, 0, 0, 0); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40 && nv < 2; c++) begin
      if (in_valid && in_ready && na < 2) begin
        acc[na] = c; na++;
      end
      if (out_valid) begin
        hs[nv] = c; cl[nv] = int'(out_class); nv++;
      end
      @(negedge clk);
      if (na == 1) in_x = px(200, 0, 0, 0, 0);
      if (na == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", na, 2);
    chk("b2b_results", nv, 2);
    chk("b2b_gap", acc[1] - hs[0], 1);
    chk("b2b_class0", cl[0], 3);
    chk("b2b_class1", cl[1], 43);
    @(negedge clk);
    load_d3();
    @(negedge clk);
    in_x = px(0, 0, 0, 7, 15); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    for (int i = 0; i < 10; i++) begin
      chk("rst_mid_no_valid", int'(out_valid), 0);
      @(negedge clk);
    end
    run(px(0, 0, 0, 7, 15), -1, '0, 0, 0, 0, 1, 8, "zero_tbl");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_dtree_ctrl.md
# seq_dtree_ctrl

Sequential decision-tree evaluator for the printed-classifier flow. It time-multiplexes one feature-select mux and one 8-bit `<=` comparator across all tree nodes. Node contents live in a writable node table. An accepted sample is walked from the root, one node per cycle, until a leaf is reached. The block replaces the fully unrolled combinational comparator tree when area matters more than latency, and sits between the sensor sample register and the class-output register.

## Interface
Parameters:
- `N_FEAT`, 5: number of input features (max 8).
- `FEAT_W`, 8: feature and threshold width.
- `NODES`, 16: node-table depth (power of two).
- `MAX_DEPTH`, 8: maximum node evaluations per sample.
- `CLASS_W`, 6: class label width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_valid`, in, 1: sample offered.
- `in_ready`, out, 1: block can accept a sample.
- `in_x`, in, N_FEAT*FEAT_W: features; feature i sits at bits [i*FEAT_W +: FEAT_W].
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer takes the result.
- `out_class`, out, CLASS_W: class label.
- `out_err`, out, 1: evaluation aborted.
- `cfg_we`, in, 1: node-table write strobe.
- `cfg_addr`, in, log2(NODES): node index.
- `cfg_data`, in, 1+3+FEAT_W+2*log2(NODES): node word, laid out as {leaf, feat[2:0], thr, left, right}. For a leaf node, the class is carried in {left, right}[CLASS_W-1:0].
- `busy`, out, 1: high in EVAL or DONE.

## Operation
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `in_x` into the sample register, set ptr=0 and step=0, go to EVAL.
- EVAL: each cycle, read node[ptr].
  - Internal node with feat >= N_FEAT: go to DONE with `out_err`=1 and `out_class`=0.
  - Internal node with step == MAX_DEPTH-1: go to DONE with `out_err`=1 and `out_class`=0.
  - Otherwise, internal node: if x[feat] <= thr (unsigned, full FEAT_W bits), ptr=left; else ptr=right. Then step++.
  - Leaf node: `out_class` = label, `out_err`=0, go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_class` and `out_err` are held stable until `out_valid`&&`out_ready`, then go to IDLE.
  - No IDLE bypass: the earliest next accept is the cycle after the output handshake.
- Config writes:
  - `cfg_we` takes effect only in IDLE.
  - In EVAL or DONE, `cfg_we` is ignored and the table is unchanged.
  - A same-edge write and accept in IDLE is legal. The write lands first-edge, so evaluation sees the new word.
- Sample register changes only on accept. `in_x` may change freely after acceptance.

## Timing
- Reset (async assert; deassert is synchronised by the parent): state=IDLE, `in_ready`=1, `out_valid`=0, `out_class`=0, `out_err`=0, `busy`=0, ptr=0, step=0.
- Reset clears the node table to all-zero. An all-zero root is an internal node that loops to node 0, so it produces `out_err` after MAX_DEPTH cycles.
- Latency for a leaf at depth d (root = depth 0): `out_valid` rises d+1 cycles after the accepting edge. Minimum latency is 1 cycle (root is a leaf); maximum is MAX_DEPTH cycles.
- Reset asserted mid-EVAL or mid-DONE: the result is discarded and no `out_valid` pulse occurs.
- `in_ready` and `out_valid` are never high in the same cycle.

## Test plan
- Table: node0={int, f0, thr 100, L1, R2}, node1=leaf 3, node2=leaf 43.
  - X0=100 -> `out_class`=3, `out_err`=0, `out_valid` 2 cycles after accept.
  - X0=101 -> `out_class`=43.
- Depth-3 path: node0={f4, thr 15, L1, R5}, node1={f1, thr 5, L2, R6}, node2={f3, thr 7, L3, R7}, node3=leaf 37. Sample X4=15, X1=0, X3=7 -> class 37, latency 4; `in_ready` low for cycles 1-4.
- Loop node0={f0, thr 255, L0, R0} -> `out_err`=1, `out_class`=0, latency exactly 8. A node with feat=6 -> `out_err`=1 after 1 cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`; `out_class` stays stable and `in_ready` stays 0. Pulse `cfg_we` on node1 while waiting; a subsequent sample still sees the old node1.
- Back-to-back: two samples with `out_ready` tied 1 and `in_valid` held -> second accept occurs the cycle after the first output handshake; both classes are correct.
- Assert `rst` during the EVAL cycle 2 of the depth-3 path -> `out_valid` stays 0, `in_ready`=1 immediately after reset, and the table reads all-zero.
